// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM
// state encoding and a small op-classification helper.
package md_pkg;

  // 4-bit MD op codes as presented by the EX stage
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // Sequencer states: IDLE accepts work, RUN models the busy latency
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the four ops that occupy the multi-cycle unit
  function automatic logic is_md_arith(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // True for the two divide ops (they use the longer latency)
  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Purely combinational multiply/divide datapath. Produces the 64-bit
// {res_hi,res_lo} result for the selected arithmetic op and flags a zero
// divisor. Signed division is done on magnitudes and then sign-corrected,
// which also makes 0x80000000 / -1 come out as quotient 0x80000000, rem 0.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // The low 64 bits of a product of sign-extended operands equal the
  // signed 32x32 product, so one unsigned 64-bit multiply covers mult.
  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign a_neg      = a[31];
  assign b_neg      = b[31];
  assign a_mag      = a_neg ? (~a + 32'd1) : a;
  assign b_mag      = b_neg ? (~b + 32'd1) : b;
  assign signed_div = (op == MD_DIV);
  assign div0       = (b == 32'd0);

  // A zero divisor is replaced by 1 so the divider never produces X;
  // the sequencer discards the result in that case anyway.
  assign dividend = signed_div ? a_mag : a;
  assign divisor  = div0 ? 32'd1 : (signed_div ? b_mag : b);
  assign quo_u    = dividend / divisor;
  assign rem_u    = dividend % divisor;

  // Quotient truncates toward zero; remainder takes the dividend's sign
  assign quo_s = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
  assign rem_s = a_neg ? (~rem_u + 32'd1) : rem_u;

  // Result select by op class
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_hi = rem_s;
        res_lo = quo_s;
      end
      MD_DIVU: begin
        res_hi = rem_u;
        res_lo = quo_u;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_seq.sv
// EX-stage multiply/divide sequencer for the 5-stage MIPS core. Accepts one
// MD op per issue, models the fixed multi-cycle latency, owns HI/LO, and
// asks the hazard unit to stall an MD instruction in ID while the unit is
// (or is about to become) occupied. An in-flight op can be cancelled.
//
// Handshake: op_valid is the valid; the unit is ready when ~busy & ~cancel.
// An op transfers only on a cycle where both hold; any op_valid presented
// while not ready is dropped (the hazard unit keeps that from happening).
module md_seq
  import md_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CW      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        id_is_md,
  input  logic        cancel,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd,
  output logic        dbg_state
);

  md_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div0;
  logic        accept;
  logic        op_is_div;
  logic [CW-1:0] lat_m1;

  md_calc u_calc (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  assign busy      = (state_q == ST_RUN);
  assign accept    = op_valid & ~busy & ~cancel;
  assign start     = accept & is_md_arith(op);
  assign stall_req = id_is_md & (busy | start);
  assign op_is_div = is_md_div(op);
  assign lat_m1    = op_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

  // Move-from read port: combinational view of the current HI/LO
  always_comb begin
    rd = 32'd0;
    case (op)
      MD_MFHI: rd = hi_q;
      MD_MFLO: rd = lo_q;
      default: rd = 32'd0;
    endcase
  end

  // Next-state, latency counter, pending result and HI/LO update
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          count_d = lat_m1;
          // A divide by zero commits the unchanged HI/LO. HI/LO cannot
          // move while busy, so snapshotting them here is equivalent.
          if (op_is_div && div0) begin
            pend_hi_d = hi_q;
            pend_lo_d = lo_q;
          end else begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
          end
        end else if (accept && (op == MD_MTHI)) begin
          hi_d = a;
        end else if (accept && (op == MD_MTLO)) begin
          lo_d = a;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          // Abort: drop the pending result, HI/LO keep pre-issue values
          state_d   = ST_IDLE;
          count_d   = '0;
          pend_hi_d = 32'd0;
          pend_lo_d = 32'd0;
        end else if (count_q == '0) begin
          state_d   = ST_IDLE;
          hi_d      = pend_hi_q;
          lo_d      = pend_lo_q;
          pend_hi_d = 32'd0;
          pend_lo_d = 32'd0;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, counter, pending and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_seq.sv
// Directed plus randomized bench for md_seq. Expected HI/LO come from a
// reference model that computes results with 64-bit integer arithmetic.
module tb_md_seq;
  import md_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  md_op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        id_is_md;
  logic        cancel;
  logic        start;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd;
  logic        dbg_state;

  always #5 clk = ~clk;

  md_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (md_op),
    .a         (a_in),
    .b         (b_in),
    .id_is_md  (id_is_md),
    .cancel    (cancel),
    .start     (start),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rd        (rd),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: result {hi,lo} of an arithmetic op given current HI/LO
  function automatic logic [63:0] model_md(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] cur);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, qv, rv, res;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    res = cur;
    case (op)
      MD_MULT:  res = sx * sy;
      MD_MULTU: res = ux * uy;
      MD_DIV: if (y != 32'd0) begin
        q = sx / sy;
        r = sx % sy;
        qv = q;
        rv = r;
        res = {rv[31:0], qv[31:0]};
      end
      MD_DIVU: if (y != 32'd0) begin
        qv = ux / uy;
        rv = ux % uy;
        res = {rv[31:0], qv[31:0]};
      end
      default: res = cur;
    endcase
    return res;
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (op == MD_DIV || op == MD_DIVU) ? DIV_LAT : MUL_LAT;
  endfunction

  // ---------------- driver tasks ----------------
  // Issue one arithmetic op, check busy/stall on every busy cycle, then
  // check the committed HI/LO. poke_last presents a mult on the commit
  // cycle, which must be ignored.
  task automatic do_arith(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic id_md, input logic poke_last);
    logic [63:0] e;
    int lat;
    lat = lat_of(op);
    @(negedge clk);
    op_valid = 1'b1; md_op = op; a_in = x; b_in = y; id_is_md = id_md;
    #1;
    chk("busy_pre", busy, 32'd0);
    chk("start_issue", start, 32'd1);
    chk("stall_issue", stall_req, id_md);
    e = model_md(op, x, y, {m_hi, m_lo});
    exp_q.push_back(e[63:32]);
    exp_q.push_back(e[31:0]);
    @(negedge clk);
    op_valid = 1'b0; md_op = MD_NONE; a_in = '0; b_in = '0;
    for (int k = 0; k < lat; k++) begin
      #1;
      chk("busy_run", busy, 32'd1);
      chk("stall_run", stall_req, id_md);
      if (poke_last && k == lat - 1) begin
        op_valid = 1'b1; md_op = MD_MULT; a_in = 32'h0000_0009; b_in = 32'h0000_0009;
        #1;
        chk("start_commit", start, 32'd0);
      end
      @(negedge clk);
      op_valid = 1'b0; md_op = MD_NONE; a_in = '0; b_in = '0;
    end
    #1;
    chk("busy_done", busy, 32'd0);
    chk("stall_done", stall_req, 32'd0);
    chk("hi_commit", hi, exp_q.pop_front());
    chk("lo_commit", lo, exp_q.pop_front());
    m_hi = e[63:32];
    m_lo = e[31:0];
    id_is_md = 1'b0;
  endtask

  // mthi/mtlo followed by the matching move-from, read on the next cycle
  task automatic do_mt(input logic [3:0] op, input logic [31:0] x);
    @(negedge clk);
    op_valid = 1'b1; md_op = op; a_in = x;
    #1;
    chk("start_mt", start, 32'd0);
    chk("busy_mt", busy, 32'd0);
    if (op == MD_MTHI) m_hi = x; else m_lo = x;
    @(negedge clk);
    md_op = (op == MD_MTHI) ? MD_MFHI : MD_MFLO; a_in = '0;
    #1;
    chk("rd_mf", rd, (op == MD_MTHI) ? m_hi : m_lo);
    chk("busy_mf", busy, 32'd0);
    op_valid = 1'b0; md_op = MD_NONE;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_hi"}, hi, 32'd0);
    chk({tag, "_lo"}, lo, 32'd0);
    chk({tag, "_rd"}, rd, 32'd0);
    chk({tag, "_start"}, start, 32'd0);
    chk({tag, "_stall"}, stall_req, 32'd0);
    chk({tag, "_state"}, dbg_state, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  rop;
    logic [31:0] rx, ry;
    reset = 1'b0; op_valid = 1'b0; md_op = MD_NONE; a_in = '0; b_in = '0;
    id_is_md = 1'b0; cancel = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    md_op = MD_MFHI;
    #1;
    chk_reset_outputs("por");
    md_op = MD_NONE;
    @(negedge clk);
    reset = 1'b1;

    // Directed arithmetic
    do_arith(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    chk("mult_hi_k", hi, 32'hFFFF_FFFF);
    chk("mult_lo_k", lo, 32'hFFFF_FFFA);
    do_arith(MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b1);
    chk("divu_lo_k", lo, 32'd3);
    chk("divu_hi_k", hi, 32'd1);
    do_arith(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("div_lo_k", lo, 32'hFFFF_FFFD);
    chk("div_hi_k", hi, 32'hFFFF_FFFF);
    do_arith(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("ovf_lo_k", lo, 32'h8000_0000);
    chk("ovf_hi_k", hi, 32'd0);

    // Move-to / move-from
    do_mt(MD_MTHI, 32'h1234_5678);
    chk("mthi_k", rd, 32'h1234_5678);
    do_mt(MD_MTLO, 32'h0BAD_F00D);

    // Cancel at busy cycle 4 of a div, with an op presented too
    do_mt(MD_MTHI, 32'h0000_AAAA);
    do_mt(MD_MTLO, 32'h0000_AAAA);
    @(negedge clk);
    op_valid = 1'b1; md_op = MD_DIV; a_in = 32'd100; b_in = 32'd7;
    #1;
    chk("cxl_start", start, 32'd1);
    @(negedge clk);
    op_valid = 1'b0; md_op = MD_NONE;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("cxl_busy", busy, 32'd1);
      @(negedge clk);
    end
    cancel = 1'b1; op_valid = 1'b1; md_op = MD_MULT; a_in = 32'd3; b_in = 32'd3;
    #1;
    chk("cxl_busy4", busy, 32'd1);
    chk("cxl_start4", start, 32'd0);
    @(negedge clk);
    cancel = 1'b0; op_valid = 1'b0; md_op = MD_NONE;
    #1;
    chk("cxl_idle", busy, 32'd0);
    chk("cxl_hi", hi, 32'h0000_AAAA);
    chk("cxl_lo", lo, 32'h0000_AAAA);
    repeat (DIV_LAT) @(negedge clk);
    #1;
    chk("cxl_hi_late", hi, 32'h0000_AAAA);
    chk("cxl_lo_late", lo, 32'h0000_AAAA);

    // Cancel in IDLE blocks both arithmetic and move-to issue
    @(negedge clk);
    cancel = 1'b1; op_valid = 1'b1; md_op = MD_MULT; a_in = 32'd5; b_in = 32'd5; id_is_md = 1'b1;
    #1;
    chk("cxi_start", start, 32'd0);
    chk("cxi_stall", stall_req, 32'd0);
    @(negedge clk);
    md_op = MD_MTHI; a_in = 32'h0000_5555; id_is_md = 1'b0;
    #1;
    chk("cxi_busy", busy, 32'd0);
    @(negedge clk);
    cancel = 1'b0; op_valid = 1'b0; md_op = MD_NONE;
    #1;
    chk("cxi_busy2", busy, 32'd0);
    chk("cxi_hi", hi, 32'h0000_AAAA);
    do_arith(MD_MULT, 32'h0001_0003, 32'h0002_0005, 1'b0, 1'b0);

    // Randomized mix
    for (int i = 0; i < 24; i++) begin
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ry = {28'd0, 4'($urandom_range(1, 15))};
      case ($urandom_range(0, 5))
        0: rop = MD_MULT;
        1: rop = MD_MULTU;
        2: rop = MD_DIV;
        3: rop = MD_DIVU;
        4: rop = MD_MTHI;
        default: rop = MD_MTLO;
      endcase
      if (is_md_arith(rop))
        do_arith(rop, rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        do_mt(rop, rx);
    end

    // Reset mid-RUN
    do_mt(MD_MTHI, 32'h0000_1111);
    do_mt(MD_MTLO, 32'h0000_2222);
    @(negedge clk);
    op_valid = 1'b1; md_op = MD_MULT; a_in = 32'd1234; b_in = 32'd5678;
    @(negedge clk);
    op_valid = 1'b0; md_op = MD_MFHI; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_run");
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1; md_op = MD_NONE;

    // Reset on the commit edge
    do_mt(MD_MTHI, 32'h0000_3333);
    @(negedge clk);
    op_valid = 1'b1; md_op = MD_MULT; a_in = 32'd2; b_in = 32'd3;
    @(negedge clk);
    op_valid = 1'b0; md_op = MD_MFLO; a_in = '0; b_in = '0;
    repeat (MUL_LAT - 1) @(negedge clk);
    #1;
    chk("rstc_busy_pre", busy, 32'd1);
    @(posedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_commit");
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1; md_op = MD_NONE;
    #1;
    chk("rstc_lo_after", lo, 32'd0);

    // Divide by zero after recovery leaves HI/LO unchanged
    do_mt(MD_MTHI, 32'hCAFE_0001);
    do_mt(MD_MTLO, 32'hBEEF_0002);
    do_arith(MD_DIV, 32'h0000_0064, 32'd0, 1'b1, 1'b0);
    chk("div0_hi", hi, 32'hCAFE_0001);
    chk("div0_lo", lo, 32'hBEEF_0002);
    do_arith(MD_DIVU, $urandom, 32'd0, 1'b0, 1'b0);
    chk("divu0_hi", hi, 32'hCAFE_0001);
    chk("divu0_lo", lo, 32'hBEEF_0002);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
